rr_feed_mux_to_demux_2: RTL and testbench

//  Upstream feeder for the 2-lane mux->demux stage. Two independent producer lanes

---
 rtl/mux_demux_pkg.sv | 16 +
 rtl/rr_pick_2.sv | 15 +
 rtl/rr_feed_mux_to_demux_2.sv | 126 ++++++++++++
 tb/tb_rr_feed_mux_to_demux_2.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_demux_pkg.sv
// Shared types for the 2-lane mux->demux feeders: FSM state, lane masks and a
// lane-index-to-one-hot helper.
package mux_demux_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } feed_state_t;

  typedef logic [1:0] lane_mask_t;

  function automatic lane_mask_t onehot2(input logic l);
    return l ? 2'b10 : 2'b01;
  endfunction

endpackage : mux_demux_pkg

// File: rtl/rr_pick_2.sv
// Two-lane round-robin pick: a lone candidate wins outright, a tie goes to the
// lane that did not win last.
module rr_pick_2
  import mux_demux_pkg::*;
(
  input  lane_mask_t i_cand,
  input  logic       i_last,
  output logic       o_any,
  output logic       o_idx
);

  assign o_any = |i_cand;
  assign o_idx = (&i_cand) ? ~i_last : i_cand[1];

endmodule : rr_pick_2

// File: rtl/rr_feed_mux_to_demux_2.sv
// Upstream feeder for mux_to_demux_2: two 1-deep holding registers and a
// round-robin presenter that holds {inp, sel, out_valid} until the lane fires.
module rr_feed_mux_to_demux_2
  import mux_demux_pkg::*;
#(
  parameter int ID    = 1,
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  lane_mask_t             in_valid,
  input  logic [1:0][WIDTH-1:0]  in_data,
  output lane_mask_t             in_ready,
  output logic [1:0][WIDTH-1:0]  inp,
  output logic                   sel,
  output lane_mask_t             out_valid,
  input  lane_mask_t             out_ready
);

  feed_state_t           r_state;
  lane_mask_t            r_full;
  logic [1:0][WIDTH-1:0] r_inp;
  logic                  r_sel;
  lane_mask_t            r_out_valid;
  logic                  r_last;

  feed_state_t w_state_nxt;
  logic        w_sel_nxt;
  lane_mask_t  w_out_valid_nxt;
  logic        w_fire;
  lane_mask_t  w_fire_mask;
  lane_mask_t  w_accept;
  lane_mask_t  w_cand;
  logic        w_any;
  logic        w_idx;

  assign w_fire      = (r_state == PRESENT) & out_ready[r_sel];
  assign w_fire_mask = w_fire ? onehot2(r_sel) : 2'b00;
  assign w_accept    = in_valid & ~r_full;
  // A word accepted this cycle only becomes a candidate once it is registered.
  assign w_cand      = r_full & ~w_fire_mask;

  rr_pick_2 u_pick (
    .i_cand (w_cand),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt     = PRESENT;
          w_sel_nxt       = w_idx;
          w_out_valid_nxt = onehot2(w_idx);
        end
      end
      PRESENT: begin
        if (w_fire) begin
          if (w_any) begin
            w_sel_nxt       = w_idx;
            w_out_valid_nxt = onehot2(w_idx);
          end else begin
            w_state_nxt     = IDLE;
            w_out_valid_nxt = 2'b00;
          end
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_out_valid_nxt = 2'b00;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= 1'b0;
      r_out_valid <= 2'b00;
      r_last      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_fire) r_last <= r_sel;
    end
  end

  // NOTE: the holding registers are reset too, because inp is a visible output with a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
      r_inp  <= '0;
    end else begin
      r_full <= (r_full & ~w_fire_mask) | w_accept;
      for (int i = 0; i < 2; i++) begin
        if (w_accept[i]) r_inp[i] <= in_data[i];
      end
    end
  end

  assign in_ready  = ~r_full;
  assign inp       = r_inp;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(r_out_valid))
    else $error("feed %0d: out_valid not one-hot", ID);

  a_valid_state : assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_valid != 2'b00) == (r_state == PRESENT))
    else $error("feed %0d: out_valid disagrees with state", ID);

  a_hold : assert property (@(posedge clk) disable iff (!rst_n)
    ((r_out_valid != 2'b00) && !w_fire) |=> ($stable(r_sel) && $stable(r_inp[r_sel])))
    else $error("feed %0d: presented word changed before fire", ID);

endmodule : rr_feed_mux_to_demux_2

// File: tb/tb_rr_feed_mux_to_demux_2.sv
// Directed and randomised checks of the round-robin feeder: reset, latency,
// ordering, backpressure, fairness and reset during a presentation.
module tb_rr_feed_mux_to_demux_2;

  logic             clk;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic [1:0][1:0]  in_data;
  logic [1:0]       in_ready;
  logic [1:0][1:0]  inp;
  logic             sel;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  rr_feed_mux_to_demux_2 #(.ID(1), .WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .inp       (inp),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 2'b00;
    out_ready = 2'b00;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  initial begin
    logic [1:0] exp_word;
    logic       fire;
    logic       prev_fire_valid;
    logic       prev_fire_lane;
    logic       prev_other_full;
    logic       hold_pending;
    logic       hold_sel;
    logic [1:0] hold_word;
    int         starve_cnt;
    int         stab_cnt;
    int         onehot_cnt;
    int         fire_cnt;

    rst_n     = 1'b0;
    in_valid  = 2'b11;
    in_data   = {2'h2, 2'h1};
    out_ready = 2'b00;

    // 1: reset with producers pushing, release, then async assert mid-cycle
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'h3);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_inp", 32'(inp), 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_accept", 32'(in_ready), 32'h0);
    in_valid = 2'b00;
    tick();
    check("first_tie_lane0_ov", 32'(out_valid), 32'h1);
    check("first_tie_lane0_sel", 32'(sel), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ov", 32'(out_valid), 32'h0);
    check("async_rst_in_ready", 32'(in_ready), 32'h3);
    check("async_rst_sel", 32'(sel), 32'h0);
    tick();
    rst_n = 1'b1;

    // 2: single lane 0 latency
    do_reset();
    in_valid  = 2'b01;
    in_data   = {2'h0, 2'h3};
    out_ready = 2'b01;
    check("l0_ready_before", 32'(in_ready[0]), 32'h1);
    tick();
    in_valid = 2'b00;
    check("l0_t_ov", 32'(out_valid), 32'h0);
    check("l0_t_ready", 32'(in_ready), 32'h2);
    tick();
    check("l0_t1_ov", 32'(out_valid), 32'h1);
    check("l0_t1_sel", 32'(sel), 32'h0);
    check("l0_t1_inp0", 32'(inp[0]), 32'h3);
    tick();
    check("l0_t2_ov", 32'(out_valid), 32'h0);
    check("l0_t2_ready", 32'(in_ready), 32'h3);

    // 3: both lanes full together, alternating order
    do_reset();
    in_valid  = 2'b11;
    in_data   = {2'h2, 2'h1};
    out_ready = 2'b11;
    tick();
    check("both_full_ready", 32'(in_ready), 32'h0);
    check("both_full_ov", 32'(out_valid), 32'h0);
    tick();
    check("order0_ov", 32'(out_valid), 32'h1);
    check("order0_inp", 32'(inp[0]), 32'h1);
    tick();
    check("order1_ov", 32'(out_valid), 32'h2);
    check("order1_sel", 32'(sel), 32'h1);
    check("order1_inp", 32'(inp[1]), 32'h2);
    check("order1_ready", 32'(in_ready), 32'h1);
    in_valid = 2'b01;
    in_data  = {2'h0, 2'h3};
    tick();
    in_valid = 2'b00;
    check("order1_fired_ov", 32'(out_valid), 32'h0);
    tick();
    check("order2_ov", 32'(out_valid), 32'h1);
    check("order2_inp", 32'(inp[0]), 32'h3);
    tick();
    check("order_drained_ov", 32'(out_valid), 32'h0);

    // 4: backpressure on lane 1 while lane 0 waits
    do_reset();
    in_valid  = 2'b10;
    in_data   = {2'h2, 2'h0};
    out_ready = 2'b00;
    tick();
    tick();
    check("bp_present_ov", 32'(out_valid), 32'h2);
    in_valid  = 2'b11;
    in_data   = {2'h1, 2'h1};
    out_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_sel", 32'(sel), 32'h1);
      check("bp_hold_inp1", 32'(inp[1]), 32'h2);
      check("bp_hold_ov", 32'(out_valid), 32'h2);
      check("bp_hold_ready1", 32'(in_ready[1]), 32'h0);
    end
    in_valid  = 2'b00;
    out_ready = 2'b10;
    tick();
    out_ready = 2'b00;
    check("bp_release_ov", 32'(out_valid), 32'h1);
    check("bp_release_sel", 32'(sel), 32'h0);
    check("bp_release_inp0", 32'(inp[0]), 32'h1);
    check("bp_release_ready1", 32'(in_ready[1]), 32'h1);

    // 6: reset mid-PRESENT with both lanes full
    do_reset();
    in_valid = 2'b11;
    in_data  = {2'h2, 2'h1};
    tick();
    in_valid = 2'b00;
    tick();
    check("mid_rst_pre_ov", 32'(out_valid), 32'h1);
    #2;
    out_ready = 2'b11;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_no_fire", 32'(out_valid & out_ready), 32'h0);
    check("mid_rst_dropped", 32'(in_ready), 32'h3);
    tick();
    check("mid_rst_edge_ov", 32'(out_valid), 32'h0);
    rst_n     = 1'b1;
    out_ready = 2'b00;
    in_valid  = 2'b10;
    in_data   = {2'h3, 2'h0};
    tick();
    in_valid = 2'b00;
    tick();
    check("mid_rst_new_ov", 32'(out_valid), 32'h2);
    check("mid_rst_new_sel", 32'(sel), 32'h1);
    check("mid_rst_new_inp1", 32'(inp[1]), 32'h3);

    // 5: randomised traffic with a per-lane scoreboard
    do_reset();
    q0.delete();
    q1.delete();
    prev_fire_valid = 1'b0;
    prev_fire_lane  = 1'b0;
    prev_other_full = 1'b0;
    hold_pending    = 1'b0;
    hold_sel        = 1'b0;
    hold_word       = 2'h0;
    starve_cnt      = 0;
    stab_cnt        = 0;
    onehot_cnt      = 0;
    fire_cnt        = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (hold_pending && (sel !== hold_sel || inp[hold_sel] !== hold_word)) stab_cnt++;
      if (out_valid == 2'b11) onehot_cnt++;
      in_valid  = 2'($urandom);
      in_data   = 4'($urandom);
      out_ready = 2'($urandom);
      fire = |(out_valid & out_ready);
      if (in_valid[0] && in_ready[0]) q0.push_back(in_data[0]);
      if (in_valid[1] && in_ready[1]) q1.push_back(in_data[1]);
      if (fire) begin
        fire_cnt++;
        if (sel) exp_word = (q1.size() > 0) ? q1.pop_front() : 2'hx;
        else     exp_word = (q0.size() > 0) ? q0.pop_front() : 2'hx;
        check("sb_word", 32'(inp[sel]), 32'(exp_word));
        check("sb_lane", 32'(out_valid), 32'(sel ? 2'b10 : 2'b01));
        if (prev_fire_valid && prev_fire_lane == sel && prev_other_full) starve_cnt++;
        prev_fire_valid = 1'b1;
        prev_fire_lane  = sel;
        prev_other_full = ~in_ready[~sel];
      end
      hold_pending = (out_valid != 2'b00) && !fire;
      hold_sel     = sel;
      hold_word    = inp[sel];
      tick();
    end
    in_valid  = 2'b00;
    out_ready = 2'b00;
    check("rand_starvation", 32'(starve_cnt), 32'h0);
    check("rand_stability", 32'(stab_cnt), 32'h0);
    check("rand_onehot", 32'(onehot_cnt), 32'h0);
    check("rand_fires_seen", 32'(fire_cnt > 200), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_feed_mux_to_demux_2
